out_of_order_buffer: RTL and testbench

//   Buffer with in-order writes and out-of-order reads. Each write stores

---
 rtl/out_of_order_buffer.sv | 96 +++++++++
 tb/tb_out_of_order_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/out_of_order_buffer.sv
// Slot buffer: writes claim the lowest free slot and report its index; reads
// release any valid slot by index, in any order, with zero-latency data.
module out_of_order_buffer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  output logic                   full,
  output logic                   empty,
  output logic [INDEX_WIDTH:0]   count,
  input  logic                   write_enable,
  input  logic [WIDTH-1:0]       write_data,
  output logic [INDEX_WIDTH-1:0] write_index,
  input  logic                   read_enable,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [WIDTH-1:0]       read_data,
  output logic                   read_hit,
  output logic                   write_overflow,
  output logic                   read_miss
);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [DEPTH-1:0]       r_valid;
  logic                   r_full;
  logic                   r_empty;
  logic [INDEX_WIDTH:0]   r_count;
  logic                   r_write_overflow;
  logic                   r_read_miss;

  logic [INDEX_WIDTH-1:0] w_write_index;
  logic                   w_write_accept;
  logic                   w_read_accept;
  logic [DEPTH-1:0]       w_write_set;
  logic [DEPTH-1:0]       w_read_clear;
  logic [DEPTH-1:0]       w_valid_next;
  logic [INDEX_WIDTH:0]   w_count_next;

  // Lowest free slot wins; when every slot is valid this falls back to 0.
  always_comb begin
    w_write_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_write_index = INDEX_WIDTH'(i);
    end
  end

  // Write is taken when write_enable && !full; read is taken when
  // read_enable && valid[read_index]. Both use pre-edge state, so they never
  // target the same slot and a freed slot is writable only the next cycle.
  assign w_write_accept = write_enable & ~r_full;
  assign w_read_accept  = read_enable & r_valid[read_index];
  assign w_write_set    = w_write_accept ? (DEPTH'(1) << w_write_index) : '0;
  assign w_read_clear   = w_read_accept  ? (DEPTH'(1) << read_index)    : '0;
  assign w_valid_next   = (r_valid | w_write_set) & ~w_read_clear;

  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_next = w_count_next + {{INDEX_WIDTH{1'b0}}, w_valid_next[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_valid          <= '0;
      r_full           <= 1'b0;
      r_empty          <= 1'b1;
      r_count          <= '0;
      r_write_overflow <= 1'b0;
      r_read_miss      <= 1'b0;
    end else begin
      r_valid          <= w_valid_next;
      r_full           <= &w_valid_next;
      r_empty          <= ~|w_valid_next;
      r_count          <= w_count_next;
      r_write_overflow <= write_enable & r_full;
      r_read_miss      <= read_enable & ~r_valid[read_index];
    end
  end

  // Payload storage has no reset; a reset cycle also blocks the write.
  always_ff @(posedge clock) begin
    if (resetn && w_write_accept) r_mem[w_write_index] <= write_data;
  end

  assign write_index    = w_write_index;
  assign read_data      = r_mem[read_index];
  assign read_hit       = r_valid[read_index];
  assign full           = r_full;
  assign empty          = r_empty;
  assign count          = r_count;
  assign write_overflow = r_write_overflow;
  assign read_miss      = r_read_miss;

endmodule

// File: tb/tb_out_of_order_buffer.sv
// Directed and randomized checks of out_of_order_buffer against a slot-array model.
module tb_out_of_order_buffer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int IW = 2;

  logic          clock;
  logic          resetn;
  logic          full;
  logic          empty;
  logic [IW:0]   count;
  logic          write_enable;
  logic [W-1:0]  write_data;
  logic [IW-1:0] write_index;
  logic          read_enable;
  logic [IW-1:0] read_index;
  logic [W-1:0]  read_data;
  logic          read_hit;
  logic          write_overflow;
  logic          read_miss;

  int total = 0;
  int bad   = 0;

  // model state
  bit           m_init = 0;
  bit           m_valid [D];
  bit           m_known [D];
  logic [W-1:0] m_mem   [D];
  bit           m_ovf;
  bit           m_miss;

  out_of_order_buffer #(.WIDTH(W), .DEPTH(D), .INDEX_WIDTH(IW)) dut (
    .clock(clock), .resetn(resetn), .full(full), .empty(empty), .count(count),
    .write_enable(write_enable), .write_data(write_data), .write_index(write_index),
    .read_enable(read_enable), .read_index(read_index), .read_data(read_data),
    .read_hit(read_hit), .write_overflow(write_overflow), .read_miss(read_miss)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < D; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  // One clock: drive inputs, check combinational outputs, step model, check registered outputs.
  task automatic do_cycle(input bit we, input logic [W-1:0] wd, input bit re, input int ri, input bit rn);
    bit f;
    int wi;
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    read_index   = IW'(ri);
    resetn       = rn;
    #1;
    if (m_init) begin
      check("write_index", 32'(write_index), 32'(m_lowest_free()));
      check("read_hit", 32'(read_hit), 32'(m_valid[ri]));
      if (m_known[ri]) check("read_data", 32'(read_data), 32'(m_mem[ri]));
    end
    if (!rn) begin
      for (int i = 0; i < D; i++) m_valid[i] = 0;
      m_ovf  = 0;
      m_miss = 0;
      m_init = 1;
    end else begin
      f      = (m_count() == D);
      wi     = m_lowest_free();
      m_ovf  = we && f;
      m_miss = re && !m_valid[ri];
      if (re && m_valid[ri]) m_valid[ri] = 0;
      if (we && !f) begin
        m_valid[wi] = 1;
        m_mem[wi]   = wd;
        m_known[wi] = 1;
      end
    end
    @(posedge clock);
    #1;
    check("full", 32'(full), 32'(m_count() == D));
    check("empty", 32'(empty), 32'(m_count() == 0));
    check("count", 32'(count), 32'(m_count()));
    check("write_overflow", 32'(write_overflow), 32'(m_ovf));
    check("read_miss", 32'(read_miss), 32'(m_miss));
  endtask

  initial begin
    write_enable = 0; write_data = '0; read_enable = 0; read_index = '0; resetn = 0;

    // 1: reset, fill four slots in order
    do_cycle(0, 8'h00, 0, 0, 0);
    do_cycle(0, 8'h00, 0, 0, 0);
    check("t1_reset_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t1_widx", 32'(write_index), 32'(i));
      do_cycle(1, 8'hA0 + 8'(i), 0, 0, 1);
    end
    check("t1_full", 32'(full), 32'd1);
    check("t1_count", 32'(count), 32'd4);

    // 2: out-of-order release, then refill lowest first
    read_index = 2'd2; #1;
    check("t2_data2", 32'(read_data), 32'hA2);
    do_cycle(0, 8'h00, 1, 2, 1);
    read_index = 2'd0; #1;
    check("t2_data0", 32'(read_data), 32'hA0);
    do_cycle(0, 8'h00, 1, 0, 1);
    check("t2_count", 32'(count), 32'd2);
    check("t2_widx0", 32'(write_index), 32'd0);
    do_cycle(1, 8'hB0, 0, 0, 1);
    check("t2_widx2", 32'(write_index), 32'd2);
    do_cycle(1, 8'hB2, 0, 0, 1);

    // 3: full write with concurrent read
    check("t3_full", 32'(full), 32'd1);
    do_cycle(1, 8'hFF, 1, 1, 1);
    check("t3_ovf", 32'(write_overflow), 32'd1);
    check("t3_count", 32'(count), 32'd3);
    check("t3_notfull", 32'(full), 32'd0);

    // 4: slots {0,1} valid, write plus read slot 0
    do_cycle(0, 8'h00, 0, 0, 0);
    do_cycle(1, 8'hC0, 0, 0, 1);
    do_cycle(1, 8'hC1, 0, 0, 1);
    do_cycle(1, 8'hC2, 1, 0, 1);
    check("t4_count", 32'(count), 32'd2);
    check("t4_widx", 32'(write_index), 32'd0);
    read_index = 2'd2; #1;
    check("t4_data2", 32'(read_data), 32'hC2);

    // 5: empty read miss
    do_cycle(0, 8'h00, 0, 0, 0);
    read_index = 2'd3; #1;
    check("t5_hit", 32'(read_hit), 32'd0);
    do_cycle(0, 8'h00, 1, 3, 1);
    check("t5_miss", 32'(read_miss), 32'd1);
    check("t5_empty", 32'(empty), 32'd1);

    // 6: reset mid-operation with a write pending
    for (int i = 0; i < 3; i++) do_cycle(1, 8'hD0 + 8'(i), 0, 0, 1);
    do_cycle(1, 8'hEE, 0, 0, 0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_count", 32'(count), 32'd0);
    check("t6_widx", 32'(write_index), 32'd0);

    // random mix
    for (int n = 0; n < 500; n++) begin
      do_cycle(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 5),
               int'($urandom_range(0, D - 1)), ($urandom_range(0, 99) >= 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
